// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: requester indices and parameter defaults.
package mem_arbiter_pkg;
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int DWIDTH_DEF    = 32;
    localparam int MEMSIZE_DEF   = 10;
    localparam int MAX_HOLD_DEF  = 16;
    localparam int CNT_WIDTH_DEF = 5;
    localparam int STALL_WIDTH   = 16;
endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester that did not win last goes.
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       sel_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        sel_o   = REQ_A;
        if (req_i == 2'b11) begin
            sel_o = ~last_i;
        end else if (req_i[REQ_B]) begin
            sel_o = REQ_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port memory: round-robin with bounded burst lock,
// and 1-cycle read-data routing back to the requester that issued the read.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DWIDTH    = DWIDTH_DEF,
    parameter int MEMSIZE   = MEMSIZE_DEF,
    parameter int MAX_HOLD  = MAX_HOLD_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   a_req,
    input  logic                   a_lock,
    input  logic                   a_we,
    input  logic [MEMSIZE-1:0]     a_addr,
    input  logic [DWIDTH-1:0]      a_wdata,
    output logic                   a_gnt,
    output logic                   a_rvalid,
    output logic [DWIDTH-1:0]      a_rdata,
    input  logic                   b_req,
    input  logic                   b_lock,
    input  logic                   b_we,
    input  logic [MEMSIZE-1:0]     b_addr,
    input  logic [DWIDTH-1:0]      b_wdata,
    output logic                   b_gnt,
    output logic                   b_rvalid,
    output logic [DWIDTH-1:0]      b_rdata,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [MEMSIZE-1:0]     mem_addr,
    output logic [DWIDTH-1:0]      mem_wdata,
    input  logic [DWIDTH-1:0]      mem_rdata,
    output logic [STALL_WIDTH-1:0] stall_cnt
);

    localparam logic [CNT_WIDTH-1:0] HOLD_MAX = CNT_WIDTH'(MAX_HOLD);

    logic [1:0] req;
    logic [1:0] lock;
    logic       pick_sel;
    logic       pick_valid;
    logic       hold_full;
    logic       keep;
    logic       sel;
    logic       any_gnt;

    logic                   owner_v_q, owner_v_d;
    logic                   owner_q, owner_d;
    logic                   last_q, last_d;
    logic [CNT_WIDTH-1:0]   hold_cnt_q, hold_cnt_d;
    logic                   a_rvalid_q, a_rvalid_d;
    logic                   b_rvalid_q, b_rvalid_d;
    logic [STALL_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    assign req  = {b_req, a_req};
    assign lock = {b_lock, a_lock};

    rr_pick2 u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .sel_o   (pick_sel),
        .valid_o (pick_valid)
    );

    // A locked owner keeps the port until it drops req/lock, or its hold budget is spent
    // while the other side is waiting.
    always_comb begin
        hold_full = (hold_cnt_q == HOLD_MAX);
        keep      = owner_v_q && req[owner_q] && lock[owner_q] && !(hold_full && req[~owner_q]);
        sel       = keep ? owner_q : pick_sel;
        any_gnt   = !rst && (keep || pick_valid);
        a_gnt     = any_gnt && (sel == REQ_A) && a_req;
        b_gnt     = any_gnt && (sel == REQ_B) && b_req;
    end

    always_comb begin
        mem_en    = a_gnt | b_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    always_comb begin
        owner_v_d  = 1'b0;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = '0;
        if (mem_en) begin
            last_d    = sel;
            owner_d   = sel;
            owner_v_d = lock[sel];
            if (owner_v_q && (sel == owner_q)) begin
                hold_cnt_d = hold_full ? hold_cnt_q : hold_cnt_q + CNT_WIDTH'(1);
            end else begin
                hold_cnt_d = CNT_WIDTH'(1);
            end
        end
        a_rvalid_d  = a_gnt && !a_we;
        b_rvalid_d  = b_gnt && !b_we;
        stall_cnt_d = stall_cnt_q;
        if (((a_req && !a_gnt) || (b_req && !b_gnt)) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_v_q   <= 1'b0;
            owner_q     <= REQ_A;
            last_q      <= REQ_B;
            hold_cnt_q  <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            owner_v_q   <= owner_v_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Memory returns data one cycle after the strobe; steer it only to the issuing side.
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = a_rvalid_q ? mem_rdata : '0;
    assign b_rdata   = b_rvalid_q ? mem_rdata : '0;
    assign stall_cnt = stall_cnt_q;

endmodule
